imem_fetch_ctrl: RTL and testbench

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/imem_fetch_ctrl.sv | 141 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: IDLE/FETCH/HALTED sequencer, 1-cycle-latency memory
// reads, 2-entry (output + skid) buffer. Optional perf counters under FETCH_PERF_CNT_EN.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        halt_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_rd_en_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_instr_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int AW = $clog2(IMEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HALTED
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_inflight;
  logic [31:0] r_inflight_pc;
  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic [31:0] r_out_pc;
  logic        r_skid_valid;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;

  logic w_accept;
  logic w_room;
  logic w_issue;

  assign w_accept = r_out_valid & ready_i;

  // A read issued now lands next cycle whatever decode does, so it must already have
  // a guaranteed slot: skid empty, and not (output held + another read landing now).
  assign w_room  = !r_skid_valid && !(r_inflight && r_out_valid && !w_accept);
  assign w_issue = (r_state == S_FETCH) && !halt_i && !redirect_i && w_room;

  assign mem_rd_en_o = w_issue;
  assign mem_addr_o  = {{(32-AW){1'b0}}, r_pc[AW+1:2]};
  assign valid_o     = r_out_valid;
  assign instr_o     = r_out_instr;
  assign pc_o        = r_out_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'd0;
      r_out_valid   <= 1'b0;
      r_out_instr   <= 32'd0;
      r_out_pc      <= 32'd0;
      r_skid_valid  <= 1'b0;
      r_skid_instr  <= 32'd0;
      r_skid_pc     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE:   if (start_i) r_state <= S_FETCH;
        S_FETCH:  if (halt_i) r_state <= S_HALTED;
        S_HALTED: if (!halt_i) r_state <= S_FETCH;
        default:  r_state <= S_IDLE;
      endcase

      if (redirect_i) begin
        // Anything buffered or returning belongs to the old path; an accept this
        // cycle has already been consumed by decode.
        r_pc         <= redirect_pc_i & 32'hFFFF_FFFC;
        r_inflight   <= 1'b0;
        r_out_valid  <= 1'b0;
        r_skid_valid <= 1'b0;
      end else begin
        r_inflight <= w_issue;
        if (w_issue) begin
          r_pc          <= r_pc + 32'd4;
          r_inflight_pc <= r_pc;
        end

        if (w_accept && r_skid_valid) begin
          r_out_instr <= r_skid_instr;
          r_out_pc    <= r_skid_pc;
          if (r_inflight) begin
            r_skid_instr <= mem_instr_i;
            r_skid_pc    <= r_inflight_pc;
          end else begin
            r_skid_valid <= 1'b0;
          end
        end else if (w_accept || !r_out_valid) begin
          r_out_valid <= r_inflight;
          if (r_inflight) begin
            r_out_instr <= mem_instr_i;
            r_out_pc    <= r_inflight_pc;
          end
        end else if (r_inflight) begin
          r_skid_valid <= 1'b1;
          r_skid_instr <= mem_instr_i;
          r_skid_pc    <= r_inflight_pc;
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_issue) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (r_out_valid && !ready_i) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o = r_fetch_cnt;
  assign stall_cnt_o = r_stall_cnt;
`else
  // Counters compiled out: no perf ports or state in this build.
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed testbench for imem_fetch_ctrl (default build, counters disabled).
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        halt_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        mem_rd_en_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_instr_i = 32'd0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  logic [31:0] mem [0:1023];
  logic [31:0] exp_pc;
  int n_checks = 0;
  int n_pass   = 0;

  imem_fetch_ctrl #(.RESET_PC(32'h0000_0000), .IMEM_DEPTH(1024)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .halt_i       (halt_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .mem_rd_en_o  (mem_rd_en_o),
    .mem_addr_o   (mem_addr_o),
    .mem_instr_i  (mem_instr_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .instr_o      (instr_o),
    .pc_o         (pc_o)
  );

  always #5 clk = ~clk;

  // Instruction memory with a registered read port.
  always @(posedge clk) if (mem_rd_en_o) mem_instr_i <= mem[mem_addr_o[9:0]];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %0b want 0", valid_o); else n_pass++;
    n_checks++; if (mem_rd_en_o !== 1'b0) $display("FAIL reset_rd_en: got %0b want 0", mem_rd_en_o); else n_pass++;
    n_checks++; if (instr_o !== 32'd0) $display("FAIL reset_instr: got %h want 0", instr_o); else n_pass++;
    n_checks++; if (pc_o !== 32'd0) $display("FAIL reset_pc: got %h want 0", pc_o); else n_pass++;
    n_checks++; if (mem_addr_o !== 32'd0) $display("FAIL reset_addr: got %h want 0", mem_addr_o); else n_pass++;
    rst_n = 1'b1;
    tick();
    #1;
    n_checks++; if (mem_rd_en_o !== 1'b0) $display("FAIL idle_rd_en: got %0b want 0", mem_rd_en_o); else n_pass++;
  endtask

  task automatic test_start_stream;
    logic [31:0] want [0:3];
    want[0] = 32'h11; want[1] = 32'h22; want[2] = 32'h33; want[3] = 32'h44;
    start_i = 1'b1;
    #1;
    n_checks++; if (mem_rd_en_o !== 1'b0) $display("FAIL start_idle_rd: got %0b want 0", mem_rd_en_o); else n_pass++;
    tick();
    start_i = 1'b0;
    #1;
    n_checks++; if (valid_o !== 1'b0) $display("FAIL start_valid_c0: got %0b want 0", valid_o); else n_pass++;
    n_checks++; if (mem_rd_en_o !== 1'b1 || mem_addr_o !== 32'd0)
      $display("FAIL start_first_read: got en=%0b addr=%h want en=1 addr=0", mem_rd_en_o, mem_addr_o); else n_pass++;
    tick();
    #1;
    n_checks++; if (valid_o !== 1'b0 || mem_addr_o !== 32'd1)
      $display("FAIL start_c1: got valid=%0b addr=%h want valid=0 addr=1", valid_o, mem_addr_o); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      $display("accept pc=%h instr=%h", pc_o, instr_o);
      n_checks++;
      if (valid_o !== 1'b1 || instr_o !== want[i] || pc_o !== 32'(i * 4))
        $display("FAIL stream_%0d: got valid=%0b instr=%h pc=%h want valid=1 instr=%h pc=%h",
                 i, valid_o, instr_o, pc_o, want[i], 32'(i * 4));
      else n_pass++;
    end
    exp_pc = 32'hC;
  endtask

  task automatic test_stall;
    logic saw_rd = 1'b0;
    for (int k = 0; k < 12; k++) begin
      ready_i = (k >= 2 && k <= 4) ? 1'b0 : 1'b1;
      #1;
      if (k == 3 || k == 4) begin
        n_checks++; if (mem_rd_en_o !== 1'b0) $display("FAIL stall_rd_en_%0d: got %0b want 0", k, mem_rd_en_o); else n_pass++;
      end
      if (k >= 2 && k <= 4) begin
        n_checks++; if (valid_o !== 1'b1) $display("FAIL stall_valid_%0d: got %0b want 1", k, valid_o); else n_pass++;
      end
      if (k >= 6 && mem_rd_en_o) saw_rd = 1'b1;
      if (valid_o && ready_i) begin
        $display("accept pc=%h instr=%h", pc_o, instr_o);
        n_checks++;
        if (pc_o !== exp_pc || instr_o !== mem[exp_pc[11:2]])
          $display("FAIL stall_order: got pc=%h instr=%h want pc=%h instr=%h", pc_o, instr_o, exp_pc, mem[exp_pc[11:2]]);
        else n_pass++;
        exp_pc += 32'd4;
      end
      tick();
    end
    n_checks++; if (saw_rd !== 1'b1) $display("FAIL stall_resume_rd: got 0 want 1"); else n_pass++;
  endtask

  task automatic test_redirect;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    #1;
    n_checks++; if (mem_rd_en_o !== 1'b0) $display("FAIL redir_rd_en: got %0b want 0", mem_rd_en_o); else n_pass++;
    if (valid_o && ready_i) begin
      $display("accept pc=%h instr=%h", pc_o, instr_o);
      n_checks++;
      if (pc_o !== exp_pc) $display("FAIL redir_consumed: got pc=%h want pc=%h", pc_o, exp_pc); else n_pass++;
    end
    tick();
    redirect_i = 1'b0;
    #1;
    n_checks++; if (valid_o !== 1'b0) $display("FAIL redir_flush: got valid=%0b want 0", valid_o); else n_pass++;
    n_checks++; if (mem_rd_en_o !== 1'b1 || mem_addr_o !== 32'h40)
      $display("FAIL redir_addr: got en=%0b addr=%h want en=1 addr=40", mem_rd_en_o, mem_addr_o); else n_pass++;
    tick();
    #1;
    n_checks++; if (valid_o !== 1'b0) $display("FAIL redir_drop: got valid=%0b pc=%h want valid=0", valid_o, pc_o); else n_pass++;
    tick();
    #1;
    n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'h100 || instr_o !== 32'hC0DE_0040)
      $display("FAIL redir_target: got valid=%0b pc=%h instr=%h want valid=1 pc=100 instr=c0de0040",
               valid_o, pc_o, instr_o); else n_pass++;
    exp_pc = 32'h100;
    for (int k = 0; k < 4; k++) begin
      if (valid_o && ready_i) begin
        $display("accept pc=%h instr=%h", pc_o, instr_o);
        n_checks++;
        if (pc_o !== exp_pc || instr_o !== mem[exp_pc[11:2]])
          $display("FAIL redir_order: got pc=%h instr=%h want pc=%h", pc_o, instr_o, exp_pc);
        else n_pass++;
        exp_pc += 32'd4;
      end
      tick();
      #1;
    end
  endtask

  task automatic test_halt;
    logic [31:0] resume_pc = 32'd0;
    for (int k = 0; k < 14; k++) begin
      halt_i = (k >= 1 && k <= 4) ? 1'b1 : 1'b0;
      #1;
      if (k >= 1 && k <= 4) begin
        n_checks++; if (mem_rd_en_o !== 1'b0) $display("FAIL halt_rd_en_%0d: got %0b want 0", k, mem_rd_en_o); else n_pass++;
      end
      if (k == 4) begin
        n_checks++; if (valid_o !== 1'b0) $display("FAIL halt_drain: got valid=%0b want 0", valid_o); else n_pass++;
      end
      if (k == 5) resume_pc = exp_pc;
      if (k == 6) begin
        n_checks++; if (mem_rd_en_o !== 1'b1 || mem_addr_o !== {22'd0, resume_pc[11:2]})
          $display("FAIL halt_resume: got en=%0b addr=%h want en=1 addr=%h", mem_rd_en_o, mem_addr_o, {22'd0, resume_pc[11:2]});
        else n_pass++;
      end
      if (valid_o && ready_i) begin
        $display("accept pc=%h instr=%h", pc_o, instr_o);
        n_checks++;
        if (pc_o !== exp_pc || instr_o !== mem[exp_pc[11:2]])
          $display("FAIL halt_order: got pc=%h instr=%h want pc=%h", pc_o, instr_o, exp_pc);
        else n_pass++;
        exp_pc += 32'd4;
      end
      tick();
    end
    n_checks++; if (exp_pc === resume_pc) $display("FAIL halt_progress: got pc=%h still, want progress", exp_pc); else n_pass++;
  endtask

  task automatic test_wrap;
    logic saw_1000 = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0FF8;
    #1;
    if (valid_o && ready_i) $display("accept pc=%h instr=%h", pc_o, instr_o);
    tick();
    redirect_i = 1'b0;
    exp_pc = 32'hFF8;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (k == 0) begin
        n_checks++; if (mem_addr_o !== 32'h3FE) $display("FAIL wrap_addr0: got %h want 3fe", mem_addr_o); else n_pass++;
      end
      if (k == 1) begin
        n_checks++; if (mem_addr_o !== 32'h3FF) $display("FAIL wrap_addr1: got %h want 3ff", mem_addr_o); else n_pass++;
      end
      if (k == 2) begin
        n_checks++; if (mem_rd_en_o !== 1'b1 || mem_addr_o !== 32'h0)
          $display("FAIL wrap_addr2: got en=%0b addr=%h want en=1 addr=0", mem_rd_en_o, mem_addr_o); else n_pass++;
      end
      if (valid_o && pc_o === 32'h1000 && instr_o === 32'h11) saw_1000 = 1'b1;
      if (valid_o && ready_i) begin
        $display("accept pc=%h instr=%h", pc_o, instr_o);
        n_checks++;
        if (pc_o !== exp_pc || instr_o !== mem[exp_pc[11:2]])
          $display("FAIL wrap_order: got pc=%h instr=%h want pc=%h", pc_o, instr_o, exp_pc);
        else n_pass++;
        exp_pc += 32'd4;
      end
      tick();
    end
    n_checks++; if (saw_1000 !== 1'b1) $display("FAIL wrap_pc1000: got 0 want pc=1000 instr=11 seen"); else n_pass++;
  endtask

  task automatic test_reset_mid;
    #1;
    n_checks++; if (valid_o !== 1'b1) $display("FAIL midrst_pre: got valid=%0b want 1", valid_o); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (valid_o !== 1'b0 || mem_rd_en_o !== 1'b0)
      $display("FAIL midrst_ctl: got valid=%0b en=%0b want 0 0", valid_o, mem_rd_en_o); else n_pass++;
    n_checks++; if (instr_o !== 32'd0 || pc_o !== 32'd0 || mem_addr_o !== 32'd0)
      $display("FAIL midrst_data: got instr=%h pc=%h addr=%h want 0 0 0", instr_o, pc_o, mem_addr_o); else n_pass++;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (mem_rd_en_o !== 1'b0 || valid_o !== 1'b0)
        $display("FAIL midrst_idle_%0d: got en=%0b valid=%0b want 0 0", k, mem_rd_en_o, valid_o); else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    exp_pc = 32'd0;
    test_reset();
    test_start_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
